// File: rtl/poli_ctrl_bank.sv
// Double-buffered NCH-channel control register bank: serial frame into a shadow
// register, atomic commit to cfg_o on apply, masked sticky status capture.
module poli_ctrl_bank #(
  parameter  int NCH    = 8,
  parameter  int CFG_W  = 4,
  parameter  int STAT_W = 2,
  localparam int TOT    = NCH * CFG_W,
  localparam int CW     = $clog2(TOT + 1),
  localparam int SW     = NCH * STAT_W
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic           sin,
  input  logic           shift_en,
  output logic           sout,
  input  logic           apply_req,
  output logic           apply_ack,
  output logic           apply_nack,
  output logic [TOT-1:0] cfg_o,
  input  logic [SW-1:0]  stat_i,
  input  logic           stat_clr,
  output logic [SW-1:0]  stat_o,
  output logic           busy,
  output logic           armed,
  output logic           err_ovf
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_ARMED = 2'd2;

  logic [1:0]     r_state;
  logic [CW-1:0]  r_count;
  logic [TOT-1:0] r_shadow;
  logic [TOT-1:0] r_cfg;
  logic [SW-1:0]  r_stat;
  logic           r_ack, r_nack, r_busy, r_armed, r_err;

  logic [1:0]     w_state_nxt;
  logic [CW-1:0]  w_count_nxt;
  logic [CW-1:0]  w_count_inc;
  logic [TOT-1:0] w_shadow_shl;
  logic [SW-1:0]  w_mask;
  logic           w_do_shift, w_ovf, w_ack, w_nack;

  generate
    if (TOT == 1) begin : g_shl_one
      assign w_shadow_shl = sin;
    end else begin : g_shl_many
      assign w_shadow_shl = {sin, r_shadow[TOT-1:1]};
    end
  endgenerate

  // Status of a channel is only captured while its enable bit is active.
  for (genvar c = 0; c < NCH; c++) begin : g_mask
    assign w_mask[c*STAT_W +: STAT_W] = {STAT_W{r_cfg[c*CFG_W + CFG_W - 1]}};
  end

  assign w_count_inc = r_count + CW'(1);

  always_comb begin
    // NOTE: every comb output gets a default first so no path can infer a latch.
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_do_shift  = 1'b0;
    w_ovf       = 1'b0;
    w_ack       = 1'b0;
    w_nack      = 1'b0;
    case (r_state)
      ST_ARMED: begin
        // Apply wins over a colliding shift; the armed frame is committed intact.
        if (apply_req) begin
          w_ack       = 1'b1;
          w_state_nxt = ST_IDLE;
          w_count_nxt = '0;
        end else if (shift_en) begin
          w_ovf       = 1'b1;
          w_do_shift  = 1'b1;
          w_count_nxt = CW'(1);
          w_state_nxt = (TOT == 1) ? ST_ARMED : ST_SHIFT;
        end
      end
      default: begin
        w_nack = apply_req;
        if (shift_en) begin
          w_do_shift  = 1'b1;
          w_count_nxt = w_count_inc;
          w_state_nxt = (w_count_inc == CW'(TOT)) ? ST_ARMED : ST_SHIFT;
        end
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state  <= ST_IDLE;
      r_count  <= '0;
      r_shadow <= '0;
      r_cfg    <= '0;
      r_stat   <= '0;
      r_ack    <= 1'b0;
      r_nack   <= 1'b0;
      r_busy   <= 1'b0;
      r_armed  <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
      r_ack   <= w_ack;
      r_nack  <= w_nack;
      r_busy  <= (w_state_nxt != ST_IDLE);
      r_armed <= (w_state_nxt == ST_ARMED);
      if (w_do_shift) r_shadow <= w_shadow_shl;
      if (w_ack)      r_cfg    <= r_shadow;
      // Clear first, then OR in new events so a same-cycle event survives.
      r_stat <= (r_stat & ~{SW{stat_clr}}) | (stat_i & w_mask);
      if (w_ovf)         r_err <= 1'b1;
      else if (stat_clr) r_err <= 1'b0;
    end
  end

  assign sout       = r_shadow[0];
  assign apply_ack  = r_ack;
  assign apply_nack = r_nack;
  assign cfg_o      = r_cfg;
  assign stat_o     = r_stat;
  assign busy       = r_busy;
  assign armed      = r_armed;
  assign err_ovf    = r_err;

endmodule
